pipeline_ctrl: RTL and testbench

Central stall/flush/exception sequencer for the five-stage Minisys-1A pipeline. It drives the hold and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It serialises three kinds of event:
- load-use stalls;
- multi-cycle divide stalls;
- precise exceptions, interrupts and `eret`, all detected at WB.

The block updates on the rising edge of `clock`. The pipeline registers sample on the falling edge, so every control output is stable half a cycle before it is consumed.

---
 rtl/pipeline_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush/exception sequencer for the five-stage pipeline.
// Events are accepted in RUN/DIV_WAIT; each flush state lasts exactly one cycle.
//
// state      | meaning
// RUN        | normal issue; load-use stall is combinational
// DIV_WAIT   | divide occupies EX; front end held, EX/MEM fed bubbles
// EXC_FLUSH  | flush all stages, redirect to handler, pulse CP0 write
// ERET_FLUSH | flush all stages, redirect to EPC, pulse CP0 eret
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_LoadUseHazard,
  input  logic        EX_DivStart,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_intruction,
  input  logic        WB_Eret,
  input  logic [31:0] WB_PC,
  input  logic [5:0]  ext_int,
  input  logic        int_enable,
  input  logic [31:0] EPC_value,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_flush,
  output logic        MEM_WB_flush,
  output logic        PC_redirect,
  output logic [31:0] PC_redirect_addr,
  output logic        CP0_exc_write,
  output logic [4:0]  CP0_cause_code,
  output logic [31:0] CP0_epc,
  output logic        CP0_eret,
  output logic        div_busy
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {RUN, DIV_WAIT, EXC_FLUSH, ERET_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    cause_q, cause_d;
  logic [31:0]   epc_q, epc_d;

  logic       sync_exc;
  logic       irq;
  logic [4:0] sync_cause;

  assign sync_exc = WB_Overflow | WB_Divide_zero | WB_Syscall | WB_Break |
                    WB_Reserved_intruction;
  assign irq      = int_enable & (|ext_int);

  always_comb begin
    if (WB_Reserved_intruction) sync_cause = 5'd10;
    else if (WB_Overflow)       sync_cause = 5'd12;
    else if (WB_Divide_zero)    sync_cause = 5'd7;
    else if (WB_Syscall)        sync_cause = 5'd8;
    else                        sync_cause = 5'd9;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    PC_stall         = 1'b0;
    IF_ID_stall      = 1'b0;
    ID_EX_stall      = 1'b0;
    IF_ID_flush      = 1'b0;
    ID_EX_flush      = 1'b0;
    EX_MEM_flush     = 1'b0;
    MEM_WB_flush     = 1'b0;
    PC_redirect      = 1'b0;
    PC_redirect_addr = '0;
    CP0_exc_write    = 1'b0;
    CP0_eret         = 1'b0;
    div_busy         = 1'b0;

    case (state_q)
      RUN, DIV_WAIT: begin
        if (state_q == DIV_WAIT) begin
          PC_stall     = 1'b1;
          IF_ID_stall  = 1'b1;
          ID_EX_stall  = 1'b1;
          EX_MEM_flush = 1'b1;
          div_busy     = 1'b1;
        end
        if (sync_exc) begin
          state_d = EXC_FLUSH;
          cause_d = sync_cause;
          epc_d   = WB_PC;
        end else if (WB_Eret) begin
          state_d = ERET_FLUSH;
        end else if (irq) begin
          // The WB instruction retires, so the handler returns to the next one.
          state_d = EXC_FLUSH;
          cause_d = 5'd0;
          epc_d   = WB_PC + 32'd4;
        end else if (state_q == DIV_WAIT) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CW'(1);
        end else if (EX_DivStart) begin
          state_d = DIV_WAIT;
          cnt_d   = CW'(DIV_CYCLES - 1);
        end else if (ID_LoadUseHazard) begin
          PC_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_EX_flush = 1'b1;
        end
      end
      EXC_FLUSH: begin
        IF_ID_flush      = 1'b1;
        ID_EX_flush      = 1'b1;
        EX_MEM_flush     = 1'b1;
        MEM_WB_flush     = 1'b1;
        PC_redirect      = 1'b1;
        PC_redirect_addr = EXC_VECTOR;
        CP0_exc_write    = 1'b1;
        state_d          = RUN;
      end
      ERET_FLUSH: begin
        IF_ID_flush      = 1'b1;
        ID_EX_flush      = 1'b1;
        EX_MEM_flush     = 1'b1;
        MEM_WB_flush     = 1'b1;
        PC_redirect      = 1'b1;
        PC_redirect_addr = EPC_value;
        CP0_eret         = 1'b1;
        state_d          = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign CP0_cause_code = cause_q;
  assign CP0_epc        = epc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge,
// outputs are sampled 1 ns later, before the next rising edge.
module tb_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ID_LoadUseHazard, EX_DivStart;
  logic        WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break;
  logic        WB_Reserved_intruction, WB_Eret;
  logic [31:0] WB_PC, EPC_value;
  logic [5:0]  ext_int;
  logic        int_enable;
  logic        PC_stall, IF_ID_stall, ID_EX_stall;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic        PC_redirect, CP0_exc_write, CP0_eret, div_busy;
  logic [31:0] PC_redirect_addr, CP0_epc;
  logic [4:0]  CP0_cause_code;

  int total = 0;
  int bad   = 0;

  // {PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush,
  //  EX_MEM_flush, MEM_WB_flush, PC_redirect, CP0_exc_write, CP0_eret, div_busy}
  logic [10:0] flags;
  assign flags = {PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush,
                  EX_MEM_flush, MEM_WB_flush, PC_redirect, CP0_exc_write,
                  CP0_eret, div_busy};

  localparam logic [10:0] F_NONE = 11'b000_0000_0000;
  localparam logic [10:0] F_LU   = 11'b110_0100_0000;
  localparam logic [10:0] F_DIV  = 11'b111_0010_0001;
  localparam logic [10:0] F_EXC  = 11'b000_1111_1100;
  localparam logic [10:0] F_ERET = 11'b000_1111_1010;

  always #5 clock = ~clock;

  pipeline_ctrl #(.DIV_CYCLES(32), .EXC_VECTOR(32'h0000_F000)) dut (
    .clock(clock), .reset(reset),
    .ID_LoadUseHazard(ID_LoadUseHazard), .EX_DivStart(EX_DivStart),
    .WB_Overflow(WB_Overflow), .WB_Divide_zero(WB_Divide_zero),
    .WB_Syscall(WB_Syscall), .WB_Break(WB_Break),
    .WB_Reserved_intruction(WB_Reserved_intruction), .WB_Eret(WB_Eret),
    .WB_PC(WB_PC), .ext_int(ext_int), .int_enable(int_enable),
    .EPC_value(EPC_value),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .PC_redirect(PC_redirect), .PC_redirect_addr(PC_redirect_addr),
    .CP0_exc_write(CP0_exc_write), .CP0_cause_code(CP0_cause_code),
    .CP0_epc(CP0_epc), .CP0_eret(CP0_eret), .div_busy(div_busy)
  );

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clear_wb();
    {WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break,
     WB_Reserved_intruction, WB_Eret} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, F_NONE); end
    total++; if (PC_redirect_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", PC_redirect_addr); end
    total++; if (CP0_cause_code !== 5'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", CP0_cause_code); end
    total++; if (CP0_epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", CP0_epc); end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL reset_idle got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_load_use();
    cyc(); ID_LoadUseHazard = 1'b1; #1;
    total++; if (flags !== F_LU) begin bad++; $display("FAIL lu_assert got=%b exp=%b", flags, F_LU); end
    cyc(); ID_LoadUseHazard = 1'b0; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL lu_release got=%b exp=%b", flags, F_NONE); end
    // Hazard coinciding with an exception is suppressed; EXC_FLUSH shows no stalls
    cyc(); ID_LoadUseHazard = 1'b1; WB_Overflow = 1'b1; WB_PC = 32'h10; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL lu_suppress_exc got=%b exp=%b", flags, F_NONE); end
    cyc(); WB_Overflow = 1'b0; #1;
    total++; if (flags !== F_EXC) begin bad++; $display("FAIL lu_in_flush got=%b exp=%b", flags, F_EXC); end
    cyc(); ID_LoadUseHazard = 1'b0; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL lu_after_flush got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_divide();
    int n_div;
    cyc(); EX_DivStart = 1'b1; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL div_start_cycle got=%b exp=%b", flags, F_NONE); end
    n_div = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      EX_DivStart = (i == 10);
      #1;
      if (flags === F_DIV) n_div++;
      total++; if (flags !== F_DIV) begin bad++; $display("FAIL div_wait_%0d got=%b exp=%b", i, flags, F_DIV); end
    end
    total++; if (n_div !== 32) begin bad++; $display("FAIL div_len got=%0d exp=32", n_div); end
    // first RUN cycle after the divide: load-use stalls normally
    cyc(); EX_DivStart = 1'b0; ID_LoadUseHazard = 1'b1; #1;
    total++; if (flags !== F_LU) begin bad++; $display("FAIL div_end_lu got=%b exp=%b", flags, F_LU); end
    cyc(); ID_LoadUseHazard = 1'b0; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL div_end_idle got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_reset_mid_div();
    cyc(); EX_DivStart = 1'b1; ID_LoadUseHazard = 1'b1; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL lu_suppress_div got=%b exp=%b", flags, F_NONE); end
    cyc(); EX_DivStart = 1'b0; ID_LoadUseHazard = 1'b0; #1;
    total++; if (flags !== F_DIV) begin bad++; $display("FAIL rst_div_enter got=%b exp=%b", flags, F_DIV); end
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL rst_mid_div got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_overflow_back_to_back();
    cyc(); WB_Overflow = 1'b1; WB_PC = 32'h0000_0040; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL ov_detect got=%b exp=%b", flags, F_NONE); end
    // flags during EXC_FLUSH must be ignored
    cyc(); WB_Overflow = 1'b0; WB_Syscall = 1'b1; WB_Break = 1'b1; WB_PC = 32'h80; #1;
    total++; if (flags !== F_EXC) begin bad++; $display("FAIL ov_flush got=%b exp=%b", flags, F_EXC); end
    total++; if (PC_redirect_addr !== 32'h0000_F000) begin bad++; $display("FAIL ov_vector got=%h exp=0000f000", PC_redirect_addr); end
    total++; if (CP0_cause_code !== 5'd12) begin bad++; $display("FAIL ov_cause got=%0d exp=12", CP0_cause_code); end
    total++; if (CP0_epc !== 32'h40) begin bad++; $display("FAIL ov_epc got=%h exp=00000040", CP0_epc); end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL ov_single_pulse got=%b exp=%b", flags, F_NONE); end
    cyc(); clear_wb(); #1;
    total++; if (flags !== F_EXC) begin bad++; $display("FAIL b2b_flush got=%b exp=%b", flags, F_EXC); end
    total++; if (CP0_cause_code !== 5'd8) begin bad++; $display("FAIL sys_brk_cause got=%0d exp=8", CP0_cause_code); end
    total++; if (CP0_epc !== 32'h80) begin bad++; $display("FAIL b2b_epc got=%h exp=00000080", CP0_epc); end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL b2b_end got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_cause_priority();
    // {Ov, DivZero, Syscall, Break, RI, Eret} -> cause
    logic [5:0] vec [5];
    logic [4:0] exp_cause [5];
    vec[0] = 6'b100011; exp_cause[0] = 5'd10;
    vec[1] = 6'b110100; exp_cause[1] = 5'd12;
    vec[2] = 6'b011000; exp_cause[2] = 5'd7;
    vec[3] = 6'b000100; exp_cause[3] = 5'd9;
    vec[4] = 6'b001001; exp_cause[4] = 5'd8;
    for (int k = 0; k < 5; k++) begin
      cyc();
      {WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break,
       WB_Reserved_intruction, WB_Eret} = vec[k];
      ext_int = 6'b000010; int_enable = 1'b1;
      WB_PC = 32'h100 + 32'(k * 4);
      cyc(); clear_wb(); ext_int = '0; int_enable = 1'b0; #1;
      total++; if (flags !== F_EXC) begin bad++; $display("FAIL prio_flush_%0d got=%b exp=%b", k, flags, F_EXC); end
      total++; if (CP0_cause_code !== exp_cause[k]) begin bad++; $display("FAIL prio_cause_%0d got=%0d exp=%0d", k, CP0_cause_code, exp_cause[k]); end
      total++; if (CP0_epc !== 32'h100 + 32'(k * 4)) begin bad++; $display("FAIL prio_epc_%0d got=%h", k, CP0_epc); end
    end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL prio_end got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_interrupt();
    cyc(); ext_int = 6'b100000; int_enable = 1'b0; WB_PC = 32'h200;
    cyc(); ext_int = '0; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL int_masked got=%b exp=%b", flags, F_NONE); end
    EX_DivStart = 1'b1;
    cyc(); EX_DivStart = 1'b0;
    for (int i = 1; i < 5; i++) cyc();
    ext_int = 6'b000001; int_enable = 1'b1; WB_PC = 32'hFFFF_FFFC; #1;
    total++; if (flags !== F_DIV) begin bad++; $display("FAIL int_div_cycle5 got=%b exp=%b", flags, F_DIV); end
    cyc(); ext_int = '0; int_enable = 1'b0; #1;
    total++; if (flags !== F_EXC) begin bad++; $display("FAIL int_flush got=%b exp=%b", flags, F_EXC); end
    total++; if (CP0_cause_code !== 5'd0) begin bad++; $display("FAIL int_cause got=%0d exp=0", CP0_cause_code); end
    total++; if (CP0_epc !== 32'h0) begin bad++; $display("FAIL int_epc_wrap got=%h exp=00000000", CP0_epc); end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL int_div_aborted got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_eret();
    cyc(); WB_Eret = 1'b1; EPC_value = 32'h0000_1234; ext_int = 6'b000100; int_enable = 1'b1; #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL eret_detect got=%b exp=%b", flags, F_NONE); end
    cyc(); WB_Eret = 1'b0; ext_int = '0; int_enable = 1'b0; #1;
    total++; if (flags !== F_ERET) begin bad++; $display("FAIL eret_flush got=%b exp=%b", flags, F_ERET); end
    total++; if (PC_redirect_addr !== 32'h1234) begin bad++; $display("FAIL eret_addr got=%h exp=00001234", PC_redirect_addr); end
    cyc(); #1;
    total++; if (flags !== F_NONE) begin bad++; $display("FAIL eret_single got=%b exp=%b", flags, F_NONE); end
  endtask

  initial begin
    reset = 1'b1;
    ID_LoadUseHazard = 1'b0; EX_DivStart = 1'b0;
    clear_wb();
    WB_PC = '0; EPC_value = '0; ext_int = '0; int_enable = 1'b0;
    test_reset();
    test_load_use();
    test_divide();
    test_reset_mid_div();
    test_overflow_back_to_back();
    test_cause_priority();
    test_interrupt();
    test_eret();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
